ctrl_vector_checker: RTL

// Synthesizable, parametrised self-check engine for the CPU control unit. It walks a

---
 rtl/ctrl_vector_checker.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ctrl_vector_checker.sv
// ctrl_vector_checker: walks a {instr, expected, mask} vector ROM, drives each instr into
// the control decoder and compares the decoder's packed control word under a per-bit mask.
module ctrl_vector_checker #(
  parameter int INSTR_W       = 32,
  parameter int EXP_W         = 9,
  parameter int ADDR_W        = 8,
  parameter int NUM_VECTORS   = 7,
  parameter int SETTLE_CYCLES = 1,
  parameter int STOP_ON_FAIL  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  vec_addr,
  input  logic [INSTR_W-1:0] vec_instr,
  input  logic [EXP_W-1:0]   vec_expected,
  input  logic [EXP_W-1:0]   vec_mask,
  output logic [INSTR_W-1:0] instr_out,
  input  logic [EXP_W-1:0]   actual_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               mismatch,
  output logic [ADDR_W:0]    fail_count,
  output logic [ADDR_W-1:0]  first_fail_idx,
  output logic [EXP_W-1:0]   first_fail_got
);

  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'((NUM_VECTORS == 0) ? 0 : NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_SETTLE  = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  vec_addr_q, vec_addr_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [EXP_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               mismatch_q, mismatch_d;
  logic [ADDR_W:0]    fail_count_q, fail_count_d;
  logic [ADDR_W-1:0]  first_fail_idx_q, first_fail_idx_d;
  logic [EXP_W-1:0]   first_fail_got_q, first_fail_got_d;
  logic               mis;

  // Only masked-in bits can fail; an X on actual_in propagates into mis.
  assign mis = |((actual_in ^ exp_q) & mask_q);

  assign vec_addr       = vec_addr_q;
  assign instr_out      = instr_out_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch       = mismatch_q;
  assign fail_count     = fail_count_q;
  assign first_fail_idx = first_fail_idx_q;
  assign first_fail_got = first_fail_got_q;

  // Next-state and next-output logic for the vector walk.
  always_comb begin
    state_d          = state_q;
    vec_addr_d       = vec_addr_q;
    instr_out_d      = instr_out_q;
    exp_d            = exp_q;
    mask_d           = mask_q;
    cnt_d            = cnt_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    mismatch_d       = 1'b0;
    fail_count_d     = fail_count_q;
    first_fail_idx_d = first_fail_idx_q;
    first_fail_got_d = first_fail_got_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_addr_d       = {ADDR_W{1'b0}};
          fail_count_d     = {(ADDR_W+1){1'b0}};
          first_fail_idx_d = {ADDR_W{1'b0}};
          first_fail_got_d = {EXP_W{1'b0}};
          if (NUM_VECTORS == 0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        instr_out_d = vec_instr;
        exp_d       = vec_expected;
        mask_d      = vec_mask;
        cnt_d       = SETTLE_LOAD;
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_COMPARE;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_COMPARE: begin
        if (mis) begin
          mismatch_d = 1'b1;
          if (fail_count_q != {(ADDR_W+1){1'b1}}) begin
            fail_count_d = fail_count_q + {{ADDR_W{1'b0}}, 1'b1};
          end else begin
            fail_count_d = fail_count_q;
          end
          if (fail_count_q == {(ADDR_W+1){1'b0}}) begin
            first_fail_idx_d = vec_addr_q;
            first_fail_got_d = actual_in;
          end else begin
            first_fail_idx_d = first_fail_idx_q;
          end
        end else begin
          mismatch_d = 1'b0;
        end
        if ((vec_addr_q == LAST_ADDR) || ((STOP_ON_FAIL != 0) && mis)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_count_d == {(ADDR_W+1){1'b0}});
        end else begin
          vec_addr_d = vec_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      vec_addr_q       <= {ADDR_W{1'b0}};
      instr_out_q      <= {INSTR_W{1'b0}};
      exp_q            <= {EXP_W{1'b0}};
      mask_q           <= {EXP_W{1'b0}};
      cnt_q            <= {CNT_W{1'b0}};
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      mismatch_q       <= 1'b0;
      fail_count_q     <= {(ADDR_W+1){1'b0}};
      first_fail_idx_q <= {ADDR_W{1'b0}};
      first_fail_got_q <= {EXP_W{1'b0}};
    end else begin
      state_q          <= state_d;
      vec_addr_q       <= vec_addr_d;
      instr_out_q      <= instr_out_d;
      exp_q            <= exp_d;
      mask_q           <= mask_d;
      cnt_q            <= cnt_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      mismatch_q       <= mismatch_d;
      fail_count_q     <= fail_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      first_fail_got_q <= first_fail_got_d;
    end
  end

endmodule
